// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage plus the MEM/WB pipeline register.
//
// The stage takes the registered EX/MEM control and data and runs one req/ack
// transaction per memory op against the data memory. While an access is
// outstanding it raises mem_stall so the upstream stages hold. Misaligned
// accesses and accesses that get no ack within TIMEOUT wait cycles turn into
// writeback bubbles that carry a one-cycle error flag.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   MEM_*                        EX/MEM register contents (address/result,
//                                store data, rd, RegWrite, MemToReg, WEN, REN)
//   dmem_req/we/addr/wdata       registered request to the data memory
//   dmem_ack, dmem_rdata         single-cycle completion pulse and load data
//   mem_stall                    combinational hold for PC/IF_ID/ID_EX/EX_MEM
//   WB_*                         MEM/WB register, WB_AddrErr/WB_BusErr pulses
module mem_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_StoreData,
  input  logic [4:0]  MEM_RD,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemToReg,
  input  logic        MEM_MEM_WEN,
  input  logic        MEM_MEM_REN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        WB_RegWrite,
  output logic        WB_MemToReg,
  output logic [4:0]  WB_RD,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_ReadData,
  output logic        WB_AddrErr,
  output logic        WB_BusErr
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_d, we_d;
  logic [31:0] addr_d, wdata_d;
  logic        wb_regwrite_d, wb_memtoreg_d, wb_addr_err_d, wb_bus_err_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_alu_d, wb_rdata_d;

  logic acc, mis, is_load, both_rw, timeout_hit;

  assign acc         = MEM_MEM_REN | MEM_MEM_WEN;
  assign mis         = acc & (MEM_ALUResult[1:0] != 2'b00);
  // With both REN and WEN set the access is performed as a write.
  assign both_rw     = MEM_MEM_REN & MEM_MEM_WEN;
  assign is_load     = MEM_MEM_REN & ~MEM_MEM_WEN;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = dmem_req;
    we_d          = dmem_we;
    addr_d        = dmem_addr;
    wdata_d       = dmem_wdata;
    mem_stall     = 1'b0;
    // Every edge loads the WB register; the default is a bubble.
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    wb_rd_d       = 5'd0;
    wb_alu_d      = 32'd0;
    wb_rdata_d    = 32'd0;
    wb_addr_err_d = 1'b0;
    wb_bus_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mis) begin
          wb_alu_d      = MEM_ALUResult;
          wb_addr_err_d = 1'b1;
        end else if (acc) begin
          mem_stall = 1'b1;
          state_d   = StWait;
          req_d     = 1'b1;
          we_d      = MEM_MEM_WEN;
          addr_d    = MEM_ALUResult;
          wdata_d   = MEM_StoreData;
          cnt_d     = '0;
        end else begin
          wb_regwrite_d = MEM_RegWrite;
          wb_memtoreg_d = MEM_MemToReg;
          wb_rd_d       = MEM_RD;
          wb_alu_d      = MEM_ALUResult;
        end
      end
      StWait: begin
        // An ack on the timeout cycle still completes the access.
        if (dmem_ack) begin
          state_d       = StIdle;
          req_d         = 1'b0;
          wb_regwrite_d = MEM_RegWrite & ~both_rw;
          wb_memtoreg_d = MEM_MemToReg;
          wb_rd_d       = MEM_RD;
          wb_alu_d      = MEM_ALUResult;
          wb_rdata_d    = is_load ? dmem_rdata : 32'd0;
        end else if (timeout_hit) begin
          state_d      = StIdle;
          req_d        = 1'b0;
          wb_bus_err_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      WB_RegWrite  <= 1'b0;
      WB_MemToReg  <= 1'b0;
      WB_RD        <= 5'd0;
      WB_ALUResult <= 32'd0;
      WB_ReadData  <= 32'd0;
      WB_AddrErr   <= 1'b0;
      WB_BusErr    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      WB_RegWrite  <= wb_regwrite_d;
      WB_MemToReg  <= wb_memtoreg_d;
      WB_RD        <= wb_rd_d;
      WB_ALUResult <= wb_alu_d;
      WB_ReadData  <= wb_rdata_d;
      WB_AddrErr   <= wb_addr_err_d;
      WB_BusErr    <= wb_bus_err_d;
    end
  end

endmodule
